// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, register-address width,
// and the bubble/NOP encodings used by the pipeline registers.
package pipe_pkg;

  localparam int REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_req;
  } ctrl_t;

  // addi x0,x0,0 loaded into IF/ID on a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // everything frozen, nothing flushed, no request
  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t ctrl_advance(input logic req);
    ctrl_t c;
    c = CTRL_NOP;
    c.pc_en     = 1'b1;
    c.if_id_en  = 1'b1;
    c.id_ex_en  = 1'b1;
    c.ex_mem_en = 1'b1;
    c.mem_wb_en = 1'b1;
    c.mem_req   = req;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the ID and EX stages.
// Per-operand hit terms are kept separate for later reuse by forwarding.
module hazard_detect #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regWrite,
  input  logic                  ex_memRd,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    load_use = ex_memRd && ex_regWrite && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use bubbles, branch squash,
// multi-cycle data-memory sequencing with timeout, stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = pipe_pkg::REG_ADDR_W,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regWrite,
  input  logic                  ex_memRd,
  input  logic                  mem_memRd,
  input  logic                  mem_memWt,
  input  logic                  mem_ack,
  input  logic                  branch_taken,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_req,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cycles
);

  import pipe_pkg::*;

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use;
  logic             mem_access;
  ctrl_t            ctrl;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_regWrite (ex_regWrite),
    .ex_memRd    (ex_memRd),
    .load_use    (load_use)
  );

  assign mem_access = mem_memRd | mem_memWt;

  always_comb begin
    ctrl    = CTRL_NOP;
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (mem_access) begin
          if (mem_ack) begin
            ctrl = ctrl_advance(1'b1);
          end else begin
            ctrl.mem_req = 1'b1;
            state_d      = MEM_WAIT;
            wait_d       = 8'd1;
          end
        end else if (branch_taken) begin
          ctrl             = ctrl_advance(1'b0);
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end else if (load_use) begin
          // hold PC and IF/ID, drop a bubble into EX
          ctrl.id_ex_en    = 1'b1;
          ctrl.id_ex_flush = 1'b1;
          ctrl.ex_mem_en   = 1'b1;
          ctrl.mem_wb_en   = 1'b1;
        end else begin
          ctrl = ctrl_advance(1'b0);
        end
      end
      MEM_WAIT: begin
        ctrl.mem_req = 1'b1;
        if (mem_ack) begin
          ctrl    = ctrl_advance(1'b1);
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q == 8'(MEM_TIMEOUT)) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ERR: begin
        ctrl = CTRL_NOP;
      end
      default: begin
        state_d = RUN;
        wait_d  = 8'd0;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (!ctrl.pc_en && (state_q != ERR) && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  // reset forces every control low without waiting for a clock
  always_comb begin
    pc_en        = ctrl.pc_en & ~reset;
    if_id_en     = ctrl.if_id_en & ~reset;
    id_ex_en     = ctrl.id_ex_en & ~reset;
    ex_mem_en    = ctrl.ex_mem_en & ~reset;
    mem_wb_en    = ctrl.mem_wb_en & ~reset;
    if_id_flush  = ctrl.if_id_flush & ~reset;
    id_ex_flush  = ctrl.id_ex_flush & ~reset;
    mem_req      = ctrl.mem_req & ~reset;
    mem_err      = (state_q == ERR) & ~reset;
    stall_cycles = stall_q;
  end

endmodule
